// File: rtl/mant_norm_ctrl_pkg.sv
// Shared types for the mantissa normalizer sequencer.
// FSM states and {S0,S1} shift-register mode codes.
package mant_norm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/mant_norm_ctrl.sv
// Left-normalizes a mantissa held in an external univ_shift_reg.
// Ports: CK/RN, IN_* upstream handshake, S0/S1/SLI/SRI/D to the
// shift register, Q from it, OUT_* downstream handshake + result.
module mant_norm_ctrl
  import mant_norm_ctrl_pkg::*;
#(
  parameter int C_NUM_BITS = 24,
  parameter int C_EXP_BITS = 8,
  parameter int C_CNT_BITS = 5
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [C_NUM_BITS-1:0] IN_MANT,
  input  logic [C_EXP_BITS-1:0] IN_EXP,
  output logic                  S0,
  output logic                  S1,
  output logic                  SLI,
  output logic                  SRI,
  output logic [C_NUM_BITS-1:0] D,
  input  logic [C_NUM_BITS-1:0] Q,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [C_EXP_BITS-1:0] OUT_EXP,
  output logic [C_CNT_BITS-1:0] OUT_SHAMT,
  output logic                  OUT_ZERO
);

  localparam logic [C_EXP_BITS-1:0] EXP_ONE = 1;
  localparam logic [C_CNT_BITS-1:0] CNT_ONE = 1;

  state_t                r_state;
  state_t                w_nxt;
  logic [C_EXP_BITS-1:0] r_exp;
  logic [C_CNT_BITS-1:0] r_cnt;
  logic                  r_zero;
  logic [1:0]            w_mode;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_shift;
  logic                  w_zhit;

  // Gated by RN so the shift register sees HOLD during reset.
  assign w_ready  = RN && (r_state == ST_IDLE);
  assign w_accept = IN_VALID && w_ready;

  always_comb begin
    w_nxt   = r_state;
    w_mode  = MODE_HOLD;
    w_shift = 1'b0;
    w_zhit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_mode = MODE_LOAD;
          w_nxt  = ST_NORM;
        end
      end
      ST_NORM: begin
        if (Q == '0) begin
          w_zhit = 1'b1;
          w_nxt  = ST_DONE;
        end else if (Q[C_NUM_BITS-1]) begin
          w_nxt = ST_DONE;
        end else if (r_exp == '0) begin
          w_nxt = ST_DONE;
        end else begin
          w_mode  = MODE_SHL;
          w_shift = 1'b1;
        end
      end
      ST_DONE: begin
        if (OUT_READY) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_IDLE;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_exp  <= IN_EXP;
        r_cnt  <= '0;
        r_zero <= 1'b0;
      end else if (w_shift) begin
        r_exp <= r_exp - EXP_ONE;
        r_cnt <= r_cnt + CNT_ONE;
      end else if (w_zhit) begin
        r_zero <= 1'b1;
        r_cnt  <= '0;
      end
    end
  end

  assign IN_READY  = w_ready;
  assign S0        = w_mode[1];
  assign S1        = w_mode[0];
  assign SLI       = 1'b0;
  assign SRI       = 1'b0;
  assign D         = IN_MANT;
  assign OUT_VALID = (r_state == ST_DONE);
  assign OUT_EXP   = r_exp;
  assign OUT_SHAMT = r_cnt;
  assign OUT_ZERO  = r_zero;

endmodule

// File: tb/tb_mant_norm_ctrl.sv
// Bench for mant_norm_ctrl with a behavioural univ_shift_reg.
// Directed, stall, reset and randomized transactions vs a model.
module tb_mant_norm_ctrl;

  localparam int N = 24;
  localparam int E = 8;
  localparam int C = 5;

  logic         ck = 1'b0;
  logic         rn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_mant = '0;
  logic [E-1:0] in_exp = '0;
  logic         s0, s1, sli, sri;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [E-1:0] out_exp;
  logic [C-1:0] out_shamt;
  logic         out_zero;

  int checks = 0;
  int failures = 0;

  always #5 ck = ~ck;

  mant_norm_ctrl #(
    .C_NUM_BITS(N),
    .C_EXP_BITS(E),
    .C_CNT_BITS(C)
  ) dut (
    .CK(ck), .RN(rn),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_MANT(in_mant), .IN_EXP(in_exp),
    .S0(s0), .S1(s1), .SLI(sli), .SRI(sri),
    .D(d), .Q(q),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_EXP(out_exp), .OUT_SHAMT(out_shamt),
    .OUT_ZERO(out_zero)
  );

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) q <= '0;
    else begin
      case ({s0, s1})
        2'b01: q <= {q[N-2:0], sli};
        2'b10: q <= {sri, q[N-1:1]};
        2'b11: q <= d;
        default: q <= q;
      endcase
    end
  end

  function automatic void model(
    input  logic [N-1:0] m,
    input  logic [E-1:0] e,
    output logic [N-1:0] qo,
    output logic [E-1:0] eo,
    output int           k,
    output bit           z
  );
    int lz;
    bit found;
    lz = 0;
    found = 0;
    z = (m == '0);
    if (z) begin
      qo = '0; eo = e; k = 0;
      return;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && m[i]) begin
        lz = N - 1 - i;
        found = 1;
      end
    end
    k = (lz < int'(e)) ? lz : int'(e);
    qo = m << k;
    eo = e - E'(k);
  endfunction

  task automatic do_accept(input logic [N-1:0] m, input logic [E-1:0] e,
                           output bit ok, output int waited);
    waited = 0;
    in_mant = m;
    in_exp = e;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge ck); #1;
      waited++;
    end
    ok = in_ready;
    if (!ok) in_valid = 1'b0;
    @(posedge ck); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit shl, output bit shr);
    lat = 1;
    shl = 0;
    shr = 0;
    while (!out_valid && lat < 100) begin
      if ({s0, s1} == 2'b01) shl = 1;
      if ({s0, s1} == 2'b10) shr = 1;
      @(posedge ck); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge ck); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rn = 1'b0;
    in_valid = 1'b1;
    in_mant = 24'h00F000;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_exp !== '0 || out_shamt !== '0 ||
        out_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs: got v=%b e=%0d s=%0d z=%b want 0 0 0 0",
               out_valid, out_exp, out_shamt, out_zero);
    end
    checks++;
    if (in_ready !== 1'b0 || {s0, s1} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mode: got rdy=%b mode=%b want 0 00",
               in_ready, {s0, s1});
    end
    in_valid = 1'b0;
    @(posedge ck); #1;
    rn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] tm [4] = '{24'h000001, 24'h800000, 24'h000000, 24'h000100};
    logic [E-1:0] te [4] = '{8'd100, 8'd5, 8'd40, 8'd3};
    logic [N-1:0] tq [4] = '{24'h800000, 24'h800000, 24'h000000, 24'h000800};
    logic [E-1:0] teo[4] = '{8'd77, 8'd5, 8'd40, 8'd0};
    int           tk [4] = '{23, 0, 0, 3};
    bit           tz [4] = '{0, 0, 1, 0};
    bit ok, shl, shr;
    int w, lat;
    for (int i = 0; i < 4; i++) begin
      do_accept(tm[i], te[i], ok, w);
      wait_valid(lat, shl, shr);
      checks++;
      if (!ok || lat != tk[i] + 2) begin
        failures++;
        $display("FAIL dir%0d_lat: got ok=%b lat=%0d want 1 %0d",
                 i, ok, lat, tk[i] + 2);
      end
      checks++;
      if (q !== tq[i] || out_exp !== teo[i] ||
          out_shamt !== C'(tk[i]) || out_zero !== tz[i]) begin
        failures++;
        $display("FAIL dir%0d_res: got q=%h e=%0d s=%0d z=%b want %h %0d %0d %b",
                 i, q, out_exp, out_shamt, out_zero,
                 tq[i], teo[i], tk[i], tz[i]);
      end
      checks++;
      if (shr || (tz[i] && shl)) begin
        failures++;
        $display("FAIL dir%0d_mode: got shl=%b shr=%b want shr=0 shl=%b",
                 i, shl, shr, !tz[i]);
      end
      release_out();
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] mq, sq;
    logic [E-1:0] me, se;
    logic [C-1:0] ss;
    bit sz, mz, ok, shl, shr;
    int mk, w, lat;
    model(24'h01A5C3, 8'd50, mq, me, mk, mz);
    do_accept(24'h01A5C3, 8'd50, ok, w);
    wait_valid(lat, shl, shr);
    checks++;
    if (lat != mk + 2 || q !== mq || out_exp !== me) begin
      failures++;
      $display("FAIL stall_res: got lat=%0d q=%h e=%0d want %0d %h %0d",
               lat, q, out_exp, mk + 2, mq, me);
    end
    sq = q; se = out_exp; ss = out_shamt; sz = out_zero;
    for (int c = 0; c < 5; c++) begin
      @(posedge ck); #1;
      checks++;
      if (q !== mq || out_exp !== me || out_shamt !== C'(mk) ||
          out_zero !== mz || out_valid !== 1'b1 ||
          {s0, s1} !== 2'b00 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got q=%h e=%0d s=%0d v=%b m=%b r=%b want %h %0d %0d 1 00 0",
                 c, q, out_exp, out_shamt, out_valid, {s0, s1},
                 in_ready, sq, se, ss);
      end
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_rel: got rdy=%b v=%b want 1 0",
               in_ready, out_valid);
    end
    do_accept(24'h400000, 8'd9, ok, w);
    wait_valid(lat, shl, shr);
    checks++;
    if (w != 0 || lat != 3 || q !== 24'h800000 || out_exp !== 8'd8 ||
        out_shamt !== 5'd1) begin
      failures++;
      $display("FAIL stall_second: got w=%0d lat=%0d q=%h e=%0d s=%0d want 0 3 800000 8 1",
               w, lat, q, out_exp, out_shamt);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    bit ok, shl, shr;
    int w, lat;
    do_accept(24'h000001, 8'd100, ok, w);
    repeat (3) begin
      @(posedge ck); #1;
    end
    #2;
    rn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_exp !== '0 || out_shamt !== '0 ||
        q !== '0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst: got v=%b e=%0d s=%0d q=%h r=%b want 0 0 0 0 0",
               out_valid, out_exp, out_shamt, q, in_ready);
    end
    @(posedge ck); #1;
    rn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_rel: got rdy=%b v=%b want 1 0",
               in_ready, out_valid);
    end
    do_accept(24'h800000, 8'd5, ok, w);
    wait_valid(lat, shl, shr);
    checks++;
    if (lat != 2 || q !== 24'h800000 || out_exp !== 8'd5 ||
        out_shamt !== '0 || out_zero !== 1'b0) begin
      failures++;
      $display("FAIL midrst_txn: got lat=%0d q=%h e=%0d s=%0d z=%b want 2 800000 5 0 0",
               lat, q, out_exp, out_shamt, out_zero);
    end
    release_out();
  endtask

  task automatic test_random(input int n, input bit b2b);
    logic [N-1:0] m, mq;
    logic [E-1:0] e, me;
    bit mz, ok, shl, shr;
    int mk, w, lat;
    for (int i = 0; i < n; i++) begin
      m = N'($urandom()) >> $urandom_range(0, N);
      e = ($urandom_range(0, 3) == 0) ? E'($urandom_range(0, 10))
                                      : E'($urandom_range(0, 255));
      model(m, e, mq, me, mk, mz);
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge ck); #1;
        end
      end
      do_accept(m, e, ok, w);
      wait_valid(lat, shl, shr);
      checks++;
      if (!ok || lat != mk + 2 || q !== mq || out_exp !== me ||
          out_shamt !== C'(mk) || out_zero !== mz || shr) begin
        failures++;
        $display("FAIL rnd%0d_%h_%0d: got lat=%0d q=%h e=%0d s=%0d z=%b want %0d %h %0d %0d %b",
                 i, m, e, lat, q, out_exp, out_shamt, out_zero,
                 mk + 2, mq, me, mk, mz);
      end
      if (b2b && i > 0) begin
        checks++;
        if (w != 0) begin
          failures++;
          $display("FAIL b2b%0d_wait: got %0d want 0", i, w);
        end
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random(30, 1'b0);
    test_random(10, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
